serial_addsub_nand: RTL and testbench

- Bit-serial adder/subtractor built around a NAND-only full-adder cell: two NAND half-adder stages plus a NAND OR for carry-out.
- Loads two WIDTH-bit operands on a start handshake and streams them LSB-first through the cell, one bit per clock.
- A carry flip-flop holds the carry between bits.
- Sits directly downstream of the NAND half-adder/full-adder cells as their sequential consumer. Gives the combinational arithmetic library a low-area multi-bit datapath.

---
 rtl/serial_addsub_nand.sv | 124 ++++++++++++
 tb/tb_serial_addsub_nand.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_nand.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// The per-bit arithmetic is a NAND-only full adder (two half adders plus an OR).
module serial_addsub_nand #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic w_last;
  logic w_n1;
  logic w_s1;
  logic w_n2;
  logic w_s;
  logic w_c;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // HA1 on the operand bits, HA2 on HA1 sum and carry-in.
  // Carry-out is c1 | c2, i.e. NAND of the two inverted half-adder carries.
  assign w_n1 = nand2(r_a[0], r_b[0]);
  assign w_s1 = nand2(nand2(r_a[0], w_n1), nand2(r_b[0], w_n1));
  assign w_n2 = nand2(w_s1, r_carry);
  assign w_s  = nand2(nand2(w_s1, w_n2), nand2(r_carry, w_n2));
  assign w_c  = nand2(w_n1, w_n2);

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cout <= w_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_res;
  assign cout   = r_cout;

endmodule

// File: tb/tb_serial_addsub_nand.sv
// Bench for serial_addsub_nand: directed vectors plus a cycle-level
// reference model compared against the DUT on every falling edge.
module tb_serial_addsub_nand;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  serial_addsub_nand #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {cout, result} from plain integer arithmetic
  function automatic logic [W:0] calc(input logic s,
                                      input logic [W-1:0] x,
                                      input logic [W-1:0] y);
    int xa;
    int ya;
    xa = int'(x);
    ya = int'(y);
    if (!s) return (W+1)'(xa + ya);
    return {(xa >= ya), W'(xa - ya)};
  endfunction

  // Model: m_t = 0 idle, 1..W busy, W+1 done.
  int           m_t;
  logic [W-1:0] m_res;
  logic         m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= 0;
      m_res  <= '0;
      m_cout <= 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t <= 1;
        {m_cout, m_res} <= calc(sub, a, b);
      end
    end else if (m_t == W + 1) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_t >= 1 && m_t <= W));
    chk("done", done, (m_t == W + 1));
    if (m_t == 0 || m_t == W + 1) begin
      chk("result", result, m_res);
      chk("cout", cout, m_cout);
    end
  end

  task automatic do_op(input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er,
                       input logic ec, input int glitch,
                       output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (glitch != 0 && i == glitch) begin
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'h11;
        b     = 8'h11;
      end
      if (glitch != 0 && i == glitch + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("done_seen", (lat != 0), 1);
    if (lat != 0) begin
      chk("op_result", result, er);
      chk("op_cout", cout, ec);
    end
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  logic [W-1:0] hx [3];
  logic [W-1:0] hy [3];
  logic         hs [3];
  logic [W-1:0] hr [3];
  logic         hc [3];

  initial begin
    int lat;
    int nb;
    int k;
    int last;
    int ndone;
    logic [W:0] e;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic rs;

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 0, lat, nb);
    chk("latency", lat, 9);
    chk("busy_cycles", nb, 8);

    do_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 0, lat, nb);
    do_op(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0, lat, nb);
    do_op(1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 0, lat, nb);
    do_op(1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 0, lat, nb);
    do_op(1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 0, lat, nb);

    do_op(1'b0, 8'hA0, 8'h05, 8'hA5, 1'b0, 3, lat, nb);
    chk("ignored_latency", lat, 9);

    // async reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h7F;
    b     = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);

    // start held high, operands changed on each done
    hx = '{8'h12, 8'h80, 8'h20};
    hy = '{8'h34, 8'h80, 8'h30};
    hs = '{1'b0, 1'b0, 1'b1};
    hr = '{8'h46, 8'h00, 8'hF0};
    hc = '{1'b0, 1'b1, 1'b0};
    @(negedge clk);
    start = 1'b1;
    sub   = hs[0];
    a     = hx[0];
    b     = hy[0];
    k     = 0;
    last  = 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      @(negedge clk);
      if (done) begin
        chk("held_result", result, hr[k]);
        chk("held_cout", cout, hc[k]);
        if (k > 0) chk("held_spacing", cyc - last, 10);
        last = cyc;
        k++;
        if (k < 3) begin
          sub = hs[k];
          a   = hx[k];
          b   = hy[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held_count", k, 3);

    for (int n = 0; n < 1000; n++) begin
      rx = W'($urandom_range(0, 255));
      ry = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      e  = calc(rs, rx, ry);
      do_op(rs, rx, ry, e[W-1:0], e[W], 0, lat, nb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
